// File: rtl/register_hl_mult.sv
// Double-wide product register: split high/low manual loads plus a sequential
// shift-and-add unsigned multiply that retires one product bit per clock.
module register_hl_mult #(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [N/2-1:0]   inh,
    input  logic [N/2-1:0]   inl,
    input  logic             loadh,
    input  logic             loadl,
    input  logic [N/2-1:0]   mcand,
    input  logic             start,
    output logic [N-1:0]     out,
    output logic             busy,
    output logic             done
);
    localparam int W  = N / 2;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [N-1:0]  r_out;
    logic [W-1:0]  r_mcand;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_state;
    logic          r_busy;
    logic          r_done;

    logic [W:0]    w_addend;
    logic [W:0]    w_sum;
    logic [N-1:0]  w_step;
    logic [N-1:0]  w_out_nxt;
    logic [W-1:0]  w_mcand_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_state_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    // One shift-and-add step: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole register right with carry-in.
    always_comb begin
        if (r_out[0]) begin
            w_addend = {1'b0, r_mcand};
        end else begin
            w_addend = '0;
        end
        w_sum  = {1'b0, r_out[N-1:W]} + w_addend;
        w_step = {w_sum, r_out[W-1:1]};
    end

    // Next-state and next-output selection; busy/done are precomputed so the
    // registered flags line up exactly with RUN and DONE.
    always_comb begin
        w_out_nxt   = r_out;
        w_mcand_nxt = r_mcand;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_out_nxt   = {{W{1'b0}}, inl};
                    w_mcand_nxt = mcand;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                    w_busy_nxt  = 1'b1;
                end else begin
                    if (loadh) begin
                        w_out_nxt[N-1:W] = inh;
                    end else begin
                        w_out_nxt[N-1:W] = r_out[N-1:W];
                    end
                    if (loadl) begin
                        w_out_nxt[W-1:0] = inl;
                    end else begin
                        w_out_nxt[W-1:0] = r_out[W-1:0];
                    end
                end
            end
            RUN: begin
                w_out_nxt = w_step;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(W - 1)) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; clear_n abandons any multiply in progress.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_out   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_out   <= w_out_nxt;
            r_mcand <= w_mcand_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_register_hl_mult.sv
// Self-checking bench for register_hl_mult (N=16): arithmetic model of the
// partial product after i steps, per-cycle compare, plus directed literal checks.
module tb_register_hl_mult;
    localparam int N = 16;
    localparam int W = N / 2;

    logic          clk;
    logic          clear_n;
    logic [W-1:0]  inh;
    logic [W-1:0]  inl;
    logic          loadh;
    logic          loadl;
    logic [W-1:0]  mcand;
    logic          start;
    logic [N-1:0]  out;
    logic          busy;
    logic          done;

    int n_cmp;
    int n_fail;

    register_hl_mult #(.N(N)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .inh     (inh),
        .inl     (inl),
        .loadh   (loadh),
        .loadl   (loadl),
        .mcand   (mcand),
        .start   (start),
        .out     (out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: after i steps the register holds (a * (b mod 2^i)) << (W-i) in its
    // upper bits and the unconsumed multiplier bits b >> i in its lower bits.
    logic [N-1:0] m_out;
    logic         m_running;
    logic         m_done;
    int           m_i;
    int           m_a;
    int           m_b;

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_out     <= '0;
            m_running <= 1'b0;
            m_done    <= 1'b0;
            m_i       <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_running) begin
            m_i   <= m_i + 1;
            m_out <= 16'((m_a * (m_b % (1 << (m_i + 1)))) << (W - 1 - m_i)) | 16'(m_b >> (m_i + 1));
            if (m_i + 1 == W) begin
                m_running <= 1'b0;
                m_done    <= 1'b1;
            end
        end else if (start) begin
            m_a       <= int'(mcand);
            m_b       <= int'(inl);
            m_i       <= 0;
            m_running <= 1'b1;
            m_out     <= {8'h00, inl};
        end else begin
            if (loadh) m_out[N-1:W] <= inh;
            if (loadl) m_out[W-1:0] <= inl;
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model, away from the edge.
    always @(posedge clk) begin
        #1;
        if (clear_n) begin
            check("cyc_out", out, m_out);
            check("cyc_busy", 16'(busy), 16'(m_running));
            check("cyc_done", 16'(done), 16'(m_done));
        end
    end

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                           input logic lh, input logic [7:0] ih, input bit disturb, input string nm);
        int  nb;
        bit  seen;
        @(negedge clk);
        mcand = a; inl = b; start = 1'b1; loadh = lh; inh = ih;
        @(negedge clk);
        start = 1'b0; loadh = 1'b0; inh = 8'h00; mcand = 8'h00; inl = 8'h00;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (busy) nb++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (disturb && i == 3) begin
                    start = 1'b1; mcand = 8'h99; inl = 8'h77; loadl = 1'b1;
                end else begin
                    start = 1'b0; loadl = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0; loadl = 1'b0;
        check({nm, "_done_seen"}, 16'(seen), 16'd1);
        check({nm, "_busy_cycles"}, 16'(nb), 16'd8);
        check({nm, "_prod_at_done"}, out, exp);
        @(negedge clk);
        check({nm, "_done_pulse"}, 16'(done), 16'd0);
        check({nm, "_busy_after"}, 16'(busy), 16'd0);
        check({nm, "_prod_held"}, out, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        clear_n = 1'b0;
        inh = 8'h00; inl = 8'h00; loadh = 1'b0; loadl = 1'b0;
        mcand = 8'h00; start = 1'b0;
        #12;
        check("rst_out", out, 16'h0000);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        @(negedge clk);
        clear_n = 1'b1;

        // Manual loads
        @(negedge clk); loadh = 1'b1; inh = 8'hAB;
        @(negedge clk); loadh = 1'b0; inh = 8'h00;
        check("man_loadh", out, 16'hAB00);
        loadl = 1'b1; inl = 8'hCD;
        @(negedge clk); loadl = 1'b0; inl = 8'h00;
        check("man_loadl", out, 16'hABCD);
        loadh = 1'b1; inh = 8'h12; loadl = 1'b1; inl = 8'h34;
        @(negedge clk); loadh = 1'b0; loadl = 1'b0; inh = 8'h00; inl = 8'h00;
        check("man_both", out, 16'h1234);
        @(negedge clk);
        check("man_hold", out, 16'h1234);

        // Multiplies
        run_mul(8'd13, 8'd11, 16'h008F, 1'b0, 8'h00, 1'b0, "m13x11");
        run_mul(8'hFF, 8'hFF, 16'hFE01, 1'b0, 8'h00, 1'b0, "mFFxFF");
        run_mul(8'h00, 8'h5A, 16'h0000, 1'b0, 8'h00, 1'b0, "m0x5A");
        run_mul(8'h80, 8'h02, 16'h0100, 1'b0, 8'h00, 1'b0, "m80x02");
        run_mul(8'h21, 8'h03, 16'h0063, 1'b1, 8'h77, 1'b0, "start_wins");
        run_mul(8'h13, 8'h07, 16'h0085, 1'b0, 8'h00, 1'b1, "run_ignore");

        // Abort mid-multiply with async reset
        @(negedge clk);
        mcand = 8'h12; inl = 8'h34; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        clear_n = 1'b0;
        #1;
        check("abort_out", out, 16'h0000);
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_done", 16'(done), 16'd0);
        @(negedge clk);
        clear_n = 1'b1;
        run_mul(8'd3, 8'd5, 16'h000F, 1'b0, 8'h00, 1'b0, "m3x5");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
